// File: rtl/fetch_align_if.sv
// fetch_align_if: fetch-memory, instruction-output and redirect signals of fetch_align_buffer.
// FETCH_ALIGN_MISALIGN_TRAP_EN adds the misalign_trap signal.
interface fetch_align_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        inst_compressed;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_MISALIGN_TRAP_EN
    logic        misalign_trap;
    modport master (
        output fetch_req, fetch_addr, inst_valid, inst_data, inst_compressed, inst_pc, misalign_trap,
        input  fetch_valid, fetch_data, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  fetch_req, fetch_addr, inst_valid, inst_data, inst_compressed, inst_pc, misalign_trap,
        output fetch_valid, fetch_data, inst_ready, redirect_valid, redirect_pc
    );
`else
    modport master (
        output fetch_req, fetch_addr, inst_valid, inst_data, inst_compressed, inst_pc,
        input  fetch_valid, fetch_data, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  fetch_req, fetch_addr, inst_valid, inst_data, inst_compressed, inst_pc,
        output fetch_valid, fetch_data, inst_ready, redirect_valid, redirect_pc
    );
`endif
endinterface

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: 4-halfword realignment FIFO turning word fetches into RV32/RVC instructions.
// FETCH_ALIGN_MISALIGN_TRAP_EN traps odd redirect targets instead of rounding them down.
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_align_if.master io
);
    logic [63:0] buf_q, buf_d;
    logic [2:0]  count_q, count_d;
    logic        inflight_q;
    logic        drop_q, drop_d;
    logic        trap_q, trap_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rpc;
    logic        is_c, head_ok, fire, acc;
    logic [1:0]  pop_n, push_n;
    logic [2:0]  base;
    logic [31:0] ins, mask;

`ifdef FETCH_ALIGN_MISALIGN_TRAP_EN
    assign rpc              = io.redirect_pc;
    assign trap_d           = io.redirect_valid ? io.redirect_pc[0] : trap_q;
    assign io.misalign_trap = trap_q;
`else
    assign rpc    = io.redirect_pc & ~32'h1;
    assign trap_d = 1'b0;
`endif

    assign is_c               = buf_q[1:0] != 2'b11;
    assign head_ok            = is_c ? count_q != 3'd0 : count_q >= 3'd2;
    assign io.inst_valid      = head_ok && !io.redirect_valid && !trap_q;
    assign io.inst_data       = !io.inst_valid ? 32'h0 : is_c ? {16'h0, buf_q[15:0]} : buf_q[31:0];
    assign io.inst_compressed = io.inst_valid && is_c;
    assign io.inst_pc         = pc_q;
    assign io.fetch_addr      = addr_q;

    assign fire   = io.inst_valid && io.inst_ready;
    assign pop_n  = !fire ? 2'd0 : is_c ? 2'd1 : 2'd2;
    assign acc    = io.fetch_valid && inflight_q && !io.redirect_valid;
    assign push_n = !acc ? 2'd0 : drop_q ? 2'd1 : 2'd2;

    // Halfwords popped this cycle count as free, so a request can overlap the pop and keep 1 IPC.
    assign io.fetch_req = !reset && !io.redirect_valid && !trap_q &&
        ({1'b0, count_q} + {2'b0, inflight_q, 1'b0} + 4'd2 <= 4'(BUF_HW) + {2'b0, pop_n});

    assign base = count_q - {1'b0, pop_n};
    assign ins  = drop_q ? {16'h0, io.fetch_data[31:16]} : io.fetch_data;
    assign mask = push_n == 2'd2 ? 32'hFFFF_FFFF : push_n == 2'd1 ? 32'h0000_FFFF : 32'h0;

    always_comb begin
        buf_d   = ((buf_q >> {pop_n, 4'b0}) & ~({32'h0, mask} << {base, 4'b0})) |
                  ({32'h0, ins & mask} << {base, 4'b0});
        count_d = io.redirect_valid ? 3'd0 : count_q + {1'b0, push_n} - {1'b0, pop_n};
        drop_d  = io.redirect_valid ? rpc[1] : acc ? 1'b0 : drop_q;
        pc_d    = io.redirect_valid ? rpc : fire ? pc_q + (is_c ? 32'd2 : 32'd4) : pc_q;
        addr_d  = io.redirect_valid ? rpc & ~32'h3 : io.fetch_req ? addr_q + 32'd4 : addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q      <= 64'h0;
            count_q    <= 3'd0;
            inflight_q <= 1'b0;
            drop_q     <= RESET_PC[1];
            trap_q     <= 1'b0;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC & ~32'h3;
        end else begin
            buf_q      <= buf_d;
            count_q    <= count_d;
            inflight_q <= io.fetch_req;
            drop_q     <= drop_d;
            trap_q     <= trap_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: randomized bench; reference walks program memory by PC to predict each instruction.
module tb_fetch_align_buffer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    fetch_align_if io();
    fetch_align_buffer #(.RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .io(io));
    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] dq_pc [$];
    logic [31:0] dq_data [$];
    logic [31:0] m_pc;
    logic [31:0] sv_data, sv_pc;
    logic        post_redir, last_req;
    int          mode, n_tests, n_fail, n_acc, a0;

    function automatic logic [15:0] rand_hw(input int md);
        logic [15:0] h = 16'($urandom);
        return md == 1 ? (h | 16'h3) : md == 2 ? (h & 16'hFFFE) : h;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = {rand_hw(mode == 1 ? 0 : mode), rand_hw(mode)};
        return mem[a];
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w = rd({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            io.fetch_valid <= 1'b0;
            io.fetch_data  <= 32'h0;
        end else begin
            io.fetch_valid <= io.fetch_req;
            io.fetch_data  <= io.fetch_req ? rd(io.fetch_addr) : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        logic [15:0] h;
        logic [31:0] ed;
        #1;
        last_req = io.fetch_req;
        if (post_redir) begin
            chk("redir_gap1", io.inst_valid, 0);
            post_redir = 1'b0;
        end
        if (!reset && io.redirect_valid) begin
            chk("redir_gap0", io.inst_valid, 0);
            m_pc = io.redirect_pc & ~32'h1;
            post_redir = 1'b1;
        end else if (!reset && io.inst_valid && io.inst_ready) begin
            h  = hw_at(m_pc);
            ed = h[1:0] != 2'b11 ? {16'h0, h} : {hw_at(m_pc + 32'd2), h};
            chk("pc", io.inst_pc, m_pc);
            chk("data", io.inst_data, ed);
            chk("cmp", io.inst_compressed, h[1:0] != 2'b11);
            if (dq_pc.size() != 0) begin
                chk("dir_pc", io.inst_pc, dq_pc.pop_front());
                chk("dir_data", io.inst_data, dq_data.pop_front());
            end
            m_pc += h[1:0] != 2'b11 ? 32'd2 : 32'd4;
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input int lim, input string tag);
        for (int i = 0; i < lim && n_acc < target; i++) cyc();
        chk(tag, n_acc >= target, 1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        io.redirect_valid = 1'b1;
        io.redirect_pc = pc;
        cyc();
        io.redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, io.fetch_req, 0);
        chk({tag, "_addr"}, io.fetch_addr, RESET_PC & ~32'h3);
        chk({tag, "_valid"}, io.inst_valid, 0);
        chk({tag, "_data"}, io.inst_data, 0);
        chk({tag, "_cmp"}, io.inst_compressed, 0);
        chk({tag, "_pc"}, io.inst_pc, RESET_PC);
    endtask

    task automatic release_reset(input string tag);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk({tag, "_first_req"}, io.fetch_req, 1);
        chk({tag, "_first_addr"}, io.fetch_addr, RESET_PC & ~32'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog n_acc=%0d", n_acc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_acc = 0; mode = 0;
        post_redir = 1'b0; last_req = 1'b0;
        io.inst_ready = 1'b0; io.redirect_valid = 1'b0; io.redirect_pc = 32'h0;
        mem[32'h000] = 32'h00A0_0093; mem[32'h004] = 32'h0041_0113; mem[32'h008] = 32'h4505_4501;
        mem[32'h020] = 32'h0093_4501; mem[32'h024] = 32'h1234_00A0;
        mem[32'h100] = 32'h4581_0001; mem[32'h300] = 32'h0093_4501;
        m_pc = RESET_PC;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("rst");
        release_reset("rst");
        io.inst_ready = 1'b1;
        dq_pc = '{32'h0, 32'h4, 32'h8, 32'hA};
        dq_data = '{32'h00A0_0093, 32'h0041_0113, 32'h0000_4501, 32'h0000_4505};
        run_until(4, 20, "boot_to");
        dq_pc = '{32'h20, 32'h22, 32'h26};
        dq_data = '{32'h0000_4501, 32'h00A0_0093, 32'h0000_1234};
        redirect(32'h20);
        run_until(n_acc + 3, 20, "straddle_to");
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (last_req) break;
        end
        chk("inflight_seen", last_req, 1);
        dq_pc = '{32'h102};
        dq_data = '{32'h0000_4581};
        redirect(32'h102);
        #1 chk("redir_addr", io.fetch_addr, 32'h100);
        chk("redir_req", io.fetch_req, 1);
        run_until(n_acc + 1, 20, "redir_to");
        chk("redir_dq_empty", dq_pc.size(), 0);
        run_until(n_acc + 3, 20, "pre_stall");
        io.inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 3) begin
                sv_data = io.inst_data; sv_pc = io.inst_pc;
                chk("stall_valid", io.inst_valid, 1);
            end else if (i > 3) begin
                chk("stall_data", io.inst_data, sv_data);
                chk("stall_pc", io.inst_pc, sv_pc);
                chk("stall_valid", io.inst_valid, 1);
            end
            if (i >= 4) chk("stall_noreq", io.fetch_req, 0);
            @(negedge clk);
        end
        io.inst_ready = 1'b1;
        run_until(n_acc + 10, 30, "resume");
        mode = 1;
        redirect(32'h1000);
        repeat (3) cyc();
        a0 = n_acc;
        repeat (16) cyc();
        chk("tput32", n_acc - a0, 16);
        mode = 2;
        redirect(32'h2000);
        repeat (3) cyc();
        a0 = n_acc;
        repeat (16) cyc();
        chk("tput16", n_acc - a0, 16);
        mode = 0;
        redirect(32'hFFFF_FFF8);
        run_until(n_acc + 12, 40, "wrap_to");
        redirect(32'h0000_0401);
        run_until(n_acc + 4, 20, "odd_to");
        for (int i = 0; i < 600; i++) begin
            io.inst_ready = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 24) == 0) begin
                mode = $urandom_range(0, 2);
                redirect(32'h4000 + $urandom_range(0, 511));
            end else cyc();
        end
        io.inst_ready = 1'b0;
        mode = 0;
        redirect(32'h302);
        repeat (2) cyc();
        #1 chk("straddle_wait", io.inst_valid, 0);
        reset = 1'b1;
        #1 chk_reset_outputs("mid");
        m_pc = RESET_PC;
        post_redir = 1'b0;
        dq_pc = '{32'h0, 32'h4};
        dq_data = '{32'h00A0_0093, 32'h0041_0113};
        @(posedge clk);
        release_reset("mid");
        io.inst_ready = 1'b1;
        run_until(n_acc + 4, 20, "restart_to");
        chk("restart_dq_empty", dq_pc.size(), 0);
        chk("progress", n_acc > 200, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
